// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, issues one outstanding word fetch
// over req/gnt/rvalid, and hands results to decode through a 1-entry buffer.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        redirect_en,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_fault,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault,
  input  logic        if_ready
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SQUASH,
    S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_pending_q, req_pending_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        buf_fault_q, buf_fault_d;

  logic        buf_free;
  logic        pc_aligned;
  logic        handshake;

  assign buf_free   = !buf_valid_q || if_ready;
  assign pc_aligned = (pc_q[1:0] == 2'b00);

  // The request depends on if_ready combinationally so a drained buffer can
  // be refilled back-to-back; req_pending keeps an issued request asserted.
  assign imem_req  = (state_q == S_REQ) && pc_aligned && (buf_free || req_pending_q);
  assign imem_addr = pc_q;
  assign handshake = imem_req && imem_gnt;

  assign if_valid = buf_valid_q;
  assign if_pc    = buf_pc_q;
  assign if_instr = buf_instr_q;
  assign if_fault = buf_fault_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    req_pending_d = req_pending_q;
    buf_valid_d   = buf_valid_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    buf_fault_d   = buf_fault_q;

    if (buf_valid_q && if_ready) begin
      buf_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (!pc_aligned) begin
          if (buf_free) begin
            buf_valid_d = 1'b1;
            buf_pc_d    = pc_q;
            buf_instr_d = NOP_INSTR;
            buf_fault_d = 1'b1;
            state_d     = S_FAULT;
          end
        end else if (handshake) begin
          req_pending_d = 1'b0;
          state_d       = S_WAIT;
        end else if (imem_req) begin
          req_pending_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          buf_valid_d = 1'b1;
          buf_pc_d    = pc_q;
          buf_instr_d = imem_rdata;
          buf_fault_d = imem_fault;
          if (imem_fault) begin
            state_d = S_FAULT;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end
      end

      S_SQUASH: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Redirect overrides everything above: new PC, flush the buffer, and
    // remember whether a response for the old PC is still on its way.
    if (redirect_en && (state_q != S_IDLE)) begin
      pc_d          = redirect_addr;
      buf_valid_d   = 1'b0;
      req_pending_d = 1'b0;
      case (state_q)
        S_REQ:    state_d = handshake ? S_SQUASH : S_REQ;
        S_WAIT:   state_d = imem_rvalid ? S_REQ : S_SQUASH;
        S_SQUASH: state_d = imem_rvalid ? S_REQ : S_SQUASH;
        S_FAULT:  state_d = S_REQ;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      req_pending_q <= 1'b0;
      buf_valid_q   <= 1'b0;
      buf_pc_q      <= 32'h0000_0000;
      buf_instr_q   <= NOP_INSTR;
      buf_fault_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pending_q <= req_pending_d;
      buf_valid_q   <= buf_valid_d;
      buf_pc_q      <= buf_pc_d;
      buf_instr_q   <= buf_instr_d;
      buf_fault_q   <= buf_fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: expected fetch addresses and decode
// entries are queued by the stimulus and popped by an independent monitor.
module tb_fetch_pc_unit;

  logic        CLK;
  logic        nRST;
  logic        redirect_en;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_fault;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;
  logic        if_ready;

  // Memory model controls: hold_addr is never granted, slow_addr answers
  // three cycles after its grant, fault_addr answers with an access fault.
  logic [31:0] hold_addr;
  logic [31:0] fault_addr;
  logic [31:0] slow_addr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

  logic [31:0] exp_req_q[$];
  entry_t      exp_out_q[$];

  int checks = 0;
  int errors = 0;

  fetch_pc_unit #(.RESET_PC(32'h0000_0100)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .redirect_en  (redirect_en),
    .redirect_addr(redirect_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .imem_fault   (imem_fault),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_fault     (if_fault),
    .if_ready     (if_ready)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] a, input string name);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(imem_req && imem_addr == a) && n < 60);
    check(name, 32'(imem_req && imem_addr == a), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!if_valid && n < 60);
    check(name, 32'(if_valid), 32'd1);
  endtask

  task automatic push_out(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    entry_t e;
    e.pc    = pc;
    e.instr = instr;
    e.fault = fault;
    exp_out_q.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_imem_req"},  32'(imem_req), 32'd0);
    check({tag, "_imem_addr"}, imem_addr,     32'h0000_0100);
    check({tag, "_if_valid"},  32'(if_valid), 32'd0);
    check({tag, "_if_pc"},     if_pc,         32'h0000_0000);
    check({tag, "_if_instr"},  if_instr,      32'h0000_0013);
    check({tag, "_if_fault"},  32'(if_fault), 32'd0);
  endtask

  // Instruction memory: grant at mid-cycle setup time, respond after latency.
  initial begin : mem_model
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    pend        = 1'b0;
    paddr       = 32'h0;
    cnt         = 0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    imem_fault  = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      imem_fault  = 1'b0;
      if (!nRST) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = {16'hC0DE, paddr[15:0]};
          imem_fault  = (paddr == fault_addr);
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
      imem_gnt = (imem_addr != hold_addr);
      @(negedge CLK);
      if (imem_req && imem_gnt) begin
        pend  = 1'b1;
        paddr = imem_addr;
        cnt   = (imem_addr == slow_addr) ? 3 : 1;
      end
    end
  end

  // Monitor: compare every granted request and every consumed entry.
  initial begin : monitor
    logic [31:0] ea;
    entry_t      eo;
    forever begin
      @(negedge CLK);
      if (imem_req && imem_gnt) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got request to %h, none expected (t=%0t)", imem_addr, $time);
        end else begin
          ea = exp_req_q.pop_front();
          check("req_addr", imem_addr, ea);
        end
      end
      if (if_valid && if_ready) begin
        if (exp_out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_entry: got pc %h instr %h, none expected (t=%0t)", if_pc, if_instr, $time);
        end else begin
          eo = exp_out_q.pop_front();
          check("entry_pc",    if_pc,           eo.pc);
          check("entry_instr", if_instr,        eo.instr);
          check("entry_fault", 32'(if_fault),   32'(eo.fault));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int lat;
    nRST          = 1'b0;
    redirect_en   = 1'b0;
    redirect_addr = 32'h0;
    if_ready      = 1'b0;
    hold_addr     = 32'hFFFF_FFFF;
    fault_addr    = 32'h0000_0001;
    slow_addr     = 32'h0000_0108;

    // Reset values, then first fetch with decode stalled.
    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    exp_req_q.push_back(32'h0000_0100);
    push_out(32'h0000_0100, 32'hC0DE_0100, 1'b0);
    tick();
    nRST = 1'b1;
    wait_req(32'h0000_0100, "first_req");
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!if_valid && lat < 10);
    check("fetch_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("bp_no_req", 32'(imem_req), 32'd0);
      check("bp_valid",  32'(if_valid), 32'd1);
    end
    check("bp_pc",    if_pc,    32'h0000_0100);
    check("bp_instr", if_instr, 32'hC0DE_0100);

    // Release decode; 0x108 answers slowly and is redirected away while pending.
    exp_req_q.push_back(32'h0000_0104);
    exp_req_q.push_back(32'h0000_0108);
    exp_req_q.push_back(32'h0000_2000);
    exp_req_q.push_back(32'h0000_2004);
    push_out(32'h0000_0104, 32'hC0DE_0104, 1'b0);
    push_out(32'h0000_2000, 32'hC0DE_2000, 1'b0);
    push_out(32'h0000_2004, 32'hC0DE_2004, 1'b0);
    hold_addr = 32'h0000_2008;
    tick();
    if_ready = 1'b1;
    wait_req(32'h0000_0108, "req_0108");
    tick();
    redirect_en   = 1'b1;
    redirect_addr = 32'h0000_2000;
    tick();
    redirect_en = 1'b0;
    @(negedge CLK);
    check("squash_no_req",   32'(imem_req), 32'd0);
    check("squash_flushed",  32'(if_valid), 32'd0);
    check("squash_new_addr", imem_addr,     32'h0000_2000);

    // Ungranted request must stay up with a stable address.
    wait_req(32'h0000_2008, "req_2008");
    tick();
    @(negedge CLK);
    check("hold_req",  32'(imem_req), 32'd1);
    check("hold_addr", imem_addr,     32'h0000_2008);

    // Redirect while ungranted, then a redirect coinciding with the grant.
    exp_req_q.push_back(32'h0000_010C);
    tick();
    redirect_en   = 1'b1;
    redirect_addr = 32'h0000_010C;
    tick();
    redirect_addr = 32'h0000_3002;
    if_ready      = 1'b0;
    @(negedge CLK);
    check("redir_req_010c",  32'(imem_req), 32'd1);
    check("redir_addr_010c", imem_addr,     32'h0000_010C);
    tick();
    redirect_en = 1'b0;
    @(negedge CLK);
    check("gnt_squash_no_req", 32'(imem_req), 32'd0);

    // Misaligned PC produces a fault entry without touching memory.
    push_out(32'h0000_3002, 32'h0000_0013, 1'b1);
    wait_valid("misalign_valid");
    check("misalign_fault", 32'(if_fault), 32'd1);
    check("misalign_pc",    if_pc,         32'h0000_3002);
    check("misalign_instr", if_instr,      32'h0000_0013);
    for (int i = 0; i < 3; i++) begin
      check("misalign_no_req", 32'(imem_req), 32'd0);
      @(negedge CLK);
    end
    tick();
    if_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("fault_drained", 32'(if_valid), 32'd0);
    check("fault_idle",    32'(imem_req), 32'd0);

    // Redirect out of FAULT restores fetching.
    exp_req_q.push_back(32'h0000_4000);
    push_out(32'h0000_4000, 32'hC0DE_4000, 1'b0);
    hold_addr = 32'h0000_4004;
    tick();
    redirect_en   = 1'b1;
    redirect_addr = 32'h0000_4000;
    tick();
    redirect_en = 1'b0;
    wait_req(32'h0000_4004, "req_4004");

    // Access fault on the response for 0x500.
    exp_req_q.push_back(32'h0000_0500);
    push_out(32'h0000_0500, 32'hC0DE_0500, 1'b1);
    fault_addr = 32'h0000_0500;
    tick();
    redirect_en   = 1'b1;
    redirect_addr = 32'h0000_0500;
    tick();
    redirect_en = 1'b0;
    wait_valid("afault_valid");
    check("afault_fault", 32'(if_fault), 32'd1);
    check("afault_pc",    if_pc,         32'h0000_0500);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("afault_no_req", 32'(imem_req), 32'd0);
      check("afault_pc_kept", imem_addr,   32'h0000_0500);
    end

    // PC wraps from 0xFFFF_FFFC to 0.
    exp_req_q.push_back(32'hFFFF_FFFC);
    exp_req_q.push_back(32'h0000_0000);
    push_out(32'hFFFF_FFFC, 32'hC0DE_FFFC, 1'b0);
    push_out(32'h0000_0000, 32'hC0DE_0000, 1'b0);
    hold_addr = 32'h0000_0004;
    tick();
    redirect_en   = 1'b1;
    redirect_addr = 32'hFFFF_FFFC;
    tick();
    redirect_en = 1'b0;
    wait_req(32'h0000_0004, "req_wrap_0004");

    // Asynchronous reset mid-operation.
    tick();
    nRST = 1'b0;
    #3;
    check_reset_values("async_reset");
    repeat (2) @(negedge CLK);
    check("req_queue_empty", 32'(exp_req_q.size()), 32'd0);
    check("out_queue_empty", 32'(exp_out_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
